imm_seq: RTL

Immediate-operand sequencer for the 16-bit datapath. On a decoder request it fetches one or two immediate bytes from the byte-wide instruction memory port, then zero-extends, sign-extends, high-loads or assembles them into a 16-bit operand. It presents the operand to the ALU operand mux over a valid/ready handshake. It owns the immediate path between decode and execute, and is the only block that drives the immediate byte-read port.

---
 rtl/imm_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imm_seq.sv
// Immediate-operand sequencer: fetches one or two immediate bytes over a byte-wide
// read port, forms a 16-bit operand and hands it over a valid/ready handshake.
module imm_seq #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              imm_valid,
  input  logic              imm_ready,
  output logic [15:0]       imm,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ZX  = 2'b00;
  localparam logic [1:0] MODE_SX  = 2'b01;
  localparam logic [1:0] MODE_W16 = 2'b10;
  localparam logic [1:0] MODE_HI  = 2'b11;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          lo_q, lo_d;
  logic                mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                imm_valid_d;
  logic [15:0]         imm_d;

  // Operand formation for the single-byte modes (two-byte mode assembles in FETCH_HI).
  function automatic logic [15:0] form_imm(input logic [1:0] mode, input logic [7:0] b0);
    logic [15:0] r;
    case (mode)
      MODE_ZX: r = {8'h00, b0};
      MODE_SX: r = {{8{b0[7]}}, b0};
      MODE_HI: r = {b0, 8'h00};
      default: r = {8'h00, b0};
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    lo_d        = lo_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    imm_valid_d = imm_valid;
    imm_d       = imm;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mode_d     = req_mode;
          addr_d     = req_addr;
          mem_addr_d = req_addr;
          state_d    = FETCH_LO;
        end
      end

      FETCH_LO: begin
        // mem_req rises one cycle after accept; an ack before that is not ours.
        if (!mem_req) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          lo_d = mem_rdata;
          if (mode_q == MODE_W16) begin
            state_d    = FETCH_HI;
            mem_addr_d = addr_q + ADDR_W'(1);
          end else begin
            state_d     = DONE;
            mem_req_d   = 1'b0;
            imm_valid_d = 1'b1;
            imm_d       = form_imm(mode_q, mem_rdata);
          end
        end
      end

      FETCH_HI: begin
        if (mem_ack) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          imm_valid_d = 1'b1;
          imm_d       = {mem_rdata, lo_q};
        end
      end

      DONE: begin
        if (imm_ready) begin
          state_d     = IDLE;
          imm_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_ZX;
      addr_q    <= '0;
      lo_q      <= 8'h00;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      imm_valid <= 1'b0;
      imm       <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      imm_valid <= imm_valid_d;
      imm       <= imm_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule
